// File: rtl/serial_fa_seq.sv
// ---------------------------------------------------------------------------
// serial_fa_seq
//
// Bit-serial addition sequencer. One external combinational full-adder cell
// is time-shared across a WIDTH-bit add: the operands are latched on a start
// request, then presented to the cell one bit pair per clock, LSB first. The
// carry recirculates through a local flop and the sum bits accumulate in a
// right-shifting register. The result is published with a one-cycle done
// pulse.
//
// Optional feature macro: SERIAL_FA_SUB_EN
//   When defined, a 'sub' input exists. With sub=1 at acceptance the B
//   operand is inverted and the carry-in is forced to 1, giving A - B, where
//   cout=1 means no borrow.
//
// Parameters
//   WIDTH    operand/result width in bits, legal range 1..64
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, accepted only when the sequencer is free
//   op_a     operand A, sampled with start
//   op_b     operand B, sampled with start
//   cin      carry-in, sampled with start
//   sub      subtract select, sampled with start (SERIAL_FA_SUB_EN only)
//   fa_out   sum output of the shared FA cell
//   fa_cout  carry output of the shared FA cell
//   busy     high while an operation is running or completing
//   done     one-cycle completion pulse
//   sum      result register, holds until the next completion
//   cout     final carry-out register, holds until the next completion
//   fa_a     FA cell input A (bit of operand A), 0 when not running
//   fa_b     FA cell input B (bit of operand B), 0 when not running
//   fa_c     FA cell carry input (recirculated carry), 0 when not running
// ---------------------------------------------------------------------------
module serial_fa_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_FA_SUB_EN
    input  logic             sub,
`endif
    input  logic             fa_out,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c
);

    // Bit counter spans 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;
    logic             running;

    // Operand conditioning at acceptance time.
    always_comb begin
        b_load     = op_b;
        carry_load = cin;
`ifdef SERIAL_FA_SUB_EN
        // Two's-complement subtract: A + ~B + 1; cin is ignored.
        if (sub) begin
            b_load     = ~op_b;
            carry_load = 1'b1;
        end
`endif
    end

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // Concatenate-then-shift keeps the expression legal for WIDTH=1.
    assign acc_next = WIDTH'({fa_out, acc_q} >> 1);
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));
    assign running  = (state_q == StRun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                // The edge that leaves the done state is also the first edge
                // at which a new request is sampled, so back-to-back requests
                // are accepted every WIDTH+1 cycles.
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= op_a;
                        b_sh_q  <= b_load;
                        carry_q <= carry_load;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                StRun: begin
                    acc_q   <= acc_next;
                    carry_q <= fa_cout;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        // Publish including the bit processed on this edge.
                        sum_q   <= acc_next;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

    // Decoded from registers only: no path from any input to these outputs.
    assign fa_a = running & a_sh_q[0];
    assign fa_b = running & b_sh_q[0];
    assign fa_c = running & carry_q;

endmodule

// File: tb/tb_serial_fa_seq.sv
module tb_serial_fa_seq;

    logic       clk;
    logic       rst_n;

    // WIDTH=8 instance
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       sub;
    logic       fa_out;
    logic       fa_cout;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       fa_a;
    logic       fa_b;
    logic       fa_c;

    // WIDTH=1 instance
    logic       start1;
    logic [0:0] op_a1;
    logic [0:0] op_b1;
    logic       cin1;
    logic       sub1;
    logic       fa_out1;
    logic       fa_cout1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic       fa_a1;
    logic       fa_b1;
    logic       fa_c1;

    int tests = 0;
    int fails = 0;

    // Behavioural model of the shared full-adder cells.
    assign fa_out   = fa_a ^ fa_b ^ fa_c;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
    assign fa_out1  = fa_a1 ^ fa_b1 ^ fa_c1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

    serial_fa_seq #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
`ifdef SERIAL_FA_SUB_EN
        .sub     (sub),
`endif
        .fa_out  (fa_out),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_c    (fa_c)
    );

    serial_fa_seq #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .op_a    (op_a1),
        .op_b    (op_b1),
        .cin     (cin1),
`ifdef SERIAL_FA_SUB_EN
        .sub     (sub1),
`endif
        .fa_out  (fa_out1),
        .fa_cout (fa_cout1),
        .busy    (busy1),
        .done    (done1),
        .sum     (sum1),
        .cout    (cout1),
        .fa_a    (fa_a1),
        .fa_b    (fa_b1),
        .fa_c    (fa_c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // One WIDTH=8 operation from idle. Operands are scrambled right after
    // acceptance to prove they were latched. hold_sum is the value sum must
    // keep for the whole run.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic s, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] hold_sum, input string tag);
        logic [7:0] bl;
        logic       c;
        bl    = s ? ~b : b;
        c     = s ? 1'b1 : ci;
        op_a  = a;
        op_b  = b;
        cin   = ci;
        sub   = s;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                start = 1'b0;
                op_a  = ~a;
                op_b  = ~b;
                cin   = ~ci;
                sub   = ~s;
            end
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_done_low"}, 64'(done), 64'd0);
            chk({tag, "_sum_hold"}, 64'(sum), 64'(hold_sum));
            chk({tag, "_fa_a"}, 64'(fa_a), 64'(a[i]));
            chk({tag, "_fa_b"}, 64'(fa_b), 64'(bl[i]));
            chk({tag, "_fa_c"}, 64'(fa_c), 64'(c));
            c = maj(a[i], bl[i], c);
        end
        tick();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        chk({tag, "_fa_idle"}, 64'({fa_a, fa_b, fa_c}), 64'd0);
        tick();
        chk({tag, "_done_end"}, 64'(done), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_sum_keep"}, 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        cin    = 1'b0;
        sub    = 1'b0;
        start1 = 1'b0;
        op_a1  = '0;
        op_b1  = '0;
        cin1   = 1'b0;
        sub1   = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic add and carry boundaries
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 8'h00, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, "add_ff_ff_c");

        // start held high: accepted every 9 cycles, operands latched
        op_a  = 8'h11;
        op_b  = 8'h22;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        op_a = 8'h40;
        op_b = 8'h05;
        chk("cont_busy0", 64'(busy), 64'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("cont_done_low1", 64'(done), 64'd0);
        end
        tick();
        chk("cont_done1", 64'(done), 64'd1);
        chk("cont_sum1", 64'(sum), 64'h33);
        tick();
        chk("cont_done_w1", 64'(done), 64'd0);
        chk("cont_busy1", 64'(busy), 64'd1);
        op_a = 8'hFF;
        op_b = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("cont_done_low2", 64'(done), 64'd0);
            chk("cont_sum_hold2", 64'(sum), 64'h33);
        end
        tick();
        chk("cont_done2", 64'(done), 64'd1);
        chk("cont_sum2", 64'(sum), 64'h45);
        chk("cont_cout2", 64'(cout), 64'd0);
        start = 1'b0;
        tick();
        chk("cont_done_w2", 64'(done), 64'd0);
        chk("cont_busy_end", 64'(busy), 64'd0);

        // Reset during bit 4 of a run
        op_a  = 8'h5A;
        op_b  = 8'h3C;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_fa_a_bit4", 64'(fa_a), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 64'(done), 64'd0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 8'h00, "add_01_02");

`ifdef SERIAL_FA_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h03, "sub_10_01");
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F, "sub_01_02");
`endif

        // WIDTH=1 instance
        op_a1  = 1'b1;
        op_b1  = 1'b1;
        cin1   = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        op_a1  = 1'b0;
        op_b1  = 1'b0;
        cin1   = 1'b0;
        chk("w1_busy", 64'(busy1), 64'd1);
        chk("w1_done_low", 64'(done1), 64'd0);
        chk("w1_fa", 64'({fa_a1, fa_b1, fa_c1}), 64'h7);
        tick();
        chk("w1_done", 64'(done1), 64'd1);
        chk("w1_sum", 64'(sum1), 64'd1);
        chk("w1_cout", 64'(cout1), 64'd1);
        tick();
        chk("w1_done_end", 64'(done1), 64'd0);
        chk("w1_busy_end", 64'(busy1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
